// File: rtl/cfg_reconfig_responder.sv
// Device-side emulator of the internal-reconfiguration port: it accepts CONFIG
// requests, emulates an image load and reports success or a sticky error.
module cfg_reconfig_responder #(
    parameter logic [3:0] VALID_MASK  = 4'b0011,
    parameter int         LOAD_CYCLES = 16,
    parameter int         CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       cfg_CBSEL,
    input  logic             cfg_ENA,
    input  logic             cfg_CONFIG,
    output logic             cfg_ERROR,
    output logic             busy,
    output logic             loaded_valid,
    output logic [1:0]       loaded_image,
    output logic [CNT_W-1:0] req_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_DONE,
        S_FAIL,
        S_WAIT_LOW
    } state_t;

    localparam logic [15:0] LOAD_INIT = 16'(LOAD_CYCLES - 1);

    state_t           state_q, state_d;
    logic             config_q;
    logic [1:0]       sel_q, sel_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic [1:0]       img_q, img_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      ld_q, ld_d;
    logic             rise;

    // config_q starts at 0, so CONFIG already high at reset release is a rise.
    assign rise = cfg_CONFIG & ~config_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        img_d   = img_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        case (state_q)
            S_IDLE: begin
                if (rise && cfg_ENA) begin
                    sel_d   = cfg_CBSEL;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (VALID_MASK[sel_q]) begin
                    ld_d    = LOAD_INIT;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_LOAD: begin
                // Losing ENA mid-load takes priority over completing the load.
                if (!cfg_ENA) begin
                    state_d = S_FAIL;
                end else if (ld_q == 16'd0) begin
                    vld_d   = 1'b1;
                    img_d   = sel_q;
                    state_d = S_DONE;
                end else begin
                    ld_d = ld_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_WAIT_LOW;
            end
            S_FAIL: begin
                err_d   = 1'b1;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!cfg_CONFIG) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            config_q <= 1'b0;
            sel_q    <= 2'd0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            img_q    <= 2'd0;
            cnt_q    <= '0;
            ld_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            config_q <= cfg_CONFIG;
            sel_q    <= sel_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
            img_q    <= img_d;
            cnt_q    <= cnt_d;
            ld_q     <= ld_d;
        end
    end

    assign busy         = (state_q == S_CHECK) || (state_q == S_LOAD);
    assign cfg_ERROR    = err_q;
    assign loaded_valid = vld_q;
    assign loaded_image = img_q;
    assign req_count    = cnt_q;

endmodule

// File: tb/tb_cfg_reconfig_responder.sv
// Directed self-checking bench for cfg_reconfig_responder (default parameters).
module tb_cfg_reconfig_responder;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] cfg_CBSEL;
    logic       cfg_ENA;
    logic       cfg_CONFIG;
    logic       cfg_ERROR;
    logic       busy;
    logic       loaded_valid;
    logic [1:0] loaded_image;
    logic [7:0] req_count;

    int checks = 0;
    int errors = 0;
    int vld_pulses = 0;
    int vld_base;
    int n;

    cfg_reconfig_responder #(
        .VALID_MASK (4'b0011),
        .LOAD_CYCLES(16),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_CBSEL   (cfg_CBSEL),
        .cfg_ENA     (cfg_ENA),
        .cfg_CONFIG  (cfg_CONFIG),
        .cfg_ERROR   (cfg_ERROR),
        .busy        (busy),
        .loaded_valid(loaded_valid),
        .loaded_image(loaded_image),
        .req_count   (req_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (loaded_valid) vld_pulses++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic back_to_idle();
        cfg_CONFIG = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rstn       = 1'b0;
        cfg_CBSEL  = 2'd1;
        cfg_ENA    = 1'b1;
        cfg_CONFIG = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", cfg_ERROR, 0);
        chk("rst_vld", loaded_valid, 0);
        chk("rst_img", loaded_image, 0);
        chk("rst_cnt", req_count, 0);
        rstn = 1'b1;
        repeat (5) tick();
        chk("idle_busy", busy, 0);

        // valid load of image 1, CONFIG held high afterwards
        vld_base   = vld_pulses;
        cfg_CONFIG = 1'b1;
        tick();
        chk("s1_cnt", req_count, 1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("s1_busy_len", n, 17);
        chk("s1_vld", loaded_valid, 1);
        chk("s1_img", loaded_image, 1);
        tick();
        chk("s1_vld_off", loaded_valid, 0);
        repeat (10) tick();
        chk("s1_no_retrig_busy", busy, 0);
        chk("s1_no_retrig_cnt", req_count, 1);
        chk("s1_err", cfg_ERROR, 0);
        chk("s1_pulses", vld_pulses - vld_base, 1);

        // invalid image 2
        cfg_CONFIG = 1'b0;
        tick();
        vld_base   = vld_pulses;
        cfg_CBSEL  = 2'd2;
        cfg_CONFIG = 1'b1;
        tick();
        chk("s2_busy", busy, 1);
        chk("s2_cnt", req_count, 2);
        tick();
        chk("s2_err_e1", cfg_ERROR, 0);
        chk("s2_busy_e1", busy, 0);
        tick();
        chk("s2_err_e2", cfg_ERROR, 1);
        repeat (3) tick();
        chk("s2_pulses", vld_pulses - vld_base, 0);
        chk("s2_img_kept", loaded_image, 1);
        chk("s2_err_sticky", cfg_ERROR, 1);

        // valid image 0 clears the error on accept
        cfg_CONFIG = 1'b0;
        tick();
        cfg_CBSEL  = 2'd0;
        cfg_CONFIG = 1'b1;
        tick();
        chk("s3_err_clr", cfg_ERROR, 0);
        chk("s3_cnt", req_count, 3);
        repeat (16) tick();
        chk("s3_vld_e16", loaded_valid, 0);
        tick();
        chk("s3_vld_e17", loaded_valid, 1);
        chk("s3_img", loaded_image, 0);

        // rise with ENA low is ignored; needs a fresh rise
        back_to_idle();
        cfg_ENA    = 1'b0;
        cfg_CONFIG = 1'b1;
        tick();
        chk("s4_busy_ena0", busy, 0);
        tick();
        cfg_ENA = 1'b1;
        tick();
        tick();
        chk("s4_busy_held", busy, 0);
        chk("s4_cnt", req_count, 3);
        cfg_CONFIG = 1'b0;
        tick();
        vld_base   = vld_pulses;
        cfg_CONFIG = 1'b1;
        tick();
        chk("s4_accept", busy, 1);
        chk("s4_cnt2", req_count, 4);

        // abort: ENA drops in the 5th LOAD cycle
        repeat (5) tick();
        chk("s5_busy", busy, 1);
        cfg_ENA = 1'b0;
        tick();
        chk("s5_busy_abort", busy, 0);
        tick();
        chk("s5_err", cfg_ERROR, 1);
        repeat (20) tick();
        chk("s5_pulses", vld_pulses - vld_base, 0);
        chk("s5_img", loaded_image, 0);

        // reset during LOAD
        cfg_ENA = 1'b1;
        back_to_idle();
        cfg_CBSEL  = 2'd1;
        cfg_CONFIG = 1'b1;
        tick();
        repeat (3) tick();
        chk("s6_busy_pre", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_cnt", req_count, 0);
        chk("s6_rst_err", cfg_ERROR, 0);
        chk("s6_rst_vld", loaded_valid, 0);
        chk("s6_rst_img", loaded_image, 0);
        cfg_CONFIG = 1'b0;
        tick();
        vld_base = vld_pulses;
        rstn     = 1'b1;
        repeat (25) tick();
        chk("s6_pulses", vld_pulses - vld_base, 0);
        chk("s6_err_after", cfg_ERROR, 0);
        chk("s6_busy_after", busy, 0);

        // req_count saturation with fast failing requests
        cfg_CBSEL = 2'd2;
        for (int i = 1; i <= 260; i++) begin
            cfg_CONFIG = 1'b1;
            tick();
            cfg_CONFIG = 1'b0;
            tick();
            tick();
            tick();
            if (i == 254) chk("s7_cnt254", req_count, 254);
            if (i == 255) chk("s7_cnt255", req_count, 255);
        end
        chk("s7_cnt_sat", req_count, 255);
        chk("s7_err", cfg_ERROR, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_reconfig_responder.md
Name: cfg_reconfig_responder

Overview:
- Synthesizable emulator of the device-side end of the internal-reconfiguration port.
- Receives cfg_CBSEL, cfg_ENA and cfg_CONFIG from an initiator and answers with cfg_ERROR, the way the configuration block would.
- Used in golden-image bring-up builds and benches so initiator logic can be exercised without a real reconfiguration.
- Also exposes load status and a request count for LED or debug observation.

Parameters:
- VALID_MASK, 4'b0011: bit i = 1 means image i exists; a request for a clear bit fails.
- LOAD_CYCLES, 16: clock cycles the emulated image load takes; legal range 1..65535.
- CNT_W, 8: width of req_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- cfg_CBSEL  in  2  image select from the initiator.
- cfg_ENA  in  1  reconfiguration enable from the initiator.
- cfg_CONFIG  in  1  reconfiguration request from the initiator; its rising edge triggers a request.
- cfg_ERROR  out  1  request failed; sticky.
- busy  out  1  a request is being processed.
- loaded_valid  out  1  one-cycle pulse when a load completes.
- loaded_image  out  2  image number of the last successful load.
- req_count  out  CNT_W  number of accepted requests; saturates at all-ones.

Behaviour:
- Reset: rstn low forces immediately state IDLE, config_d=0, cfg_ERROR=0, busy=0, loaded_valid=0, loaded_image=0, req_count=0, load counter=0.
- config_d is the cfg_CONFIG value registered each clock. rise = cfg_CONFIG & ~config_d.
- If cfg_CONFIG is already high at reset release, that counts as a rise on the first clock.
- States: IDLE, CHECK, LOAD, DONE, FAIL, WAIT_LOW.
- IDLE:
  - accept = rise & cfg_ENA.
  - On accept: latch sel_q=cfg_CBSEL, clear cfg_ERROR, increment req_count (saturating), go to CHECK.
  - A rise with cfg_ENA=0 is ignored: no state change, no count, cfg_ERROR unchanged. A later rise is still needed to trigger.
- CHECK, exactly 1 cycle:
  - If VALID_MASK[sel_q]=1: load counter = LOAD_CYCLES-1, go to LOAD.
  - Otherwise go to FAIL.
- LOAD:
  - Counter decrements each cycle; at 0 go to DONE, so LOAD lasts exactly LOAD_CYCLES cycles.
  - cfg_ENA=0 in any LOAD cycle aborts to FAIL on that edge.
  - cfg_CBSEL changes are ignored (sel_q is latched). cfg_CONFIG may fall; the load continues.
- DONE, 1 cycle: loaded_valid=1 and loaded_image=sel_q (registered on entry); then go to WAIT_LOW.
- FAIL, 1 cycle: cfg_ERROR set to 1 on entry; then go to WAIT_LOW. loaded_image is unchanged.
- WAIT_LOW:
  - Stay while cfg_CONFIG=1; go to IDLE in the cycle cfg_CONFIG=0.
  - This prevents retriggering from an initiator that holds CONFIG high.
  - config_d keeps tracking, so a new rise from IDLE requires an observed low first.
- busy=1 exactly in CHECK and LOAD.
- cfg_ERROR stays 1 until the next accepted request or reset.
- Latency, with the accept edge as edge 0:
  - Valid image: loaded_valid high in the cycle after edge LOAD_CYCLES+1, for one cycle.
  - Invalid image: cfg_ERROR rises after edge 2.
- sel_q index is 0..3 into the 4-bit VALID_MASK; no out-of-range case exists.
- req_count saturation: at all-ones, further accepts leave it unchanged.
- Reset mid-operation: all state clears immediately; no loaded_valid or cfg_ERROR is produced for the interrupted request.

Test Plan:
- Reset release, cfg_CONFIG=0, cfg_ENA=1, cfg_CBSEL=1 held 5 clocks, then cfg_CONFIG 0->1 and held high:
  - busy high for 1+16 cycles, then loaded_valid one pulse and loaded_image=1.
  - cfg_ERROR stays 0, req_count=1, no second trigger while CONFIG stays high.
- cfg_CBSEL=2 with default mask, CONFIG rise and ENA=1 -> cfg_ERROR=1 two edges after accept, no loaded_valid, loaded_image keeps its old value.
- Then drop CONFIG, set CBSEL=0 and rise CONFIG again -> cfg_ERROR clears on accept; loaded_valid with loaded_image=0 after 18 edges.
- CONFIG rise with cfg_ENA=0 -> no busy, req_count unchanged. Raise ENA while CONFIG stays high -> still no request until CONFIG goes low then high.
- Valid request, then drop cfg_ENA at the 5th LOAD cycle -> FAIL; cfg_ERROR=1, busy=0, no loaded_valid.
- Assert rstn=0 during LOAD -> all outputs 0 immediately.
- Run 260 accepted requests with CNT_W=8 -> req_count stops at 255.
